uart_cmd_wrapper: RTL and testbench
===================================

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_000_000, is the maximum number of clk cycles allowed between the high-byte and low-byte receptions of one command.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 RX  input  1  serial receive line, 8N1 at the codebase UART baud.
REQ-005 TX  output  1  serial transmit line, 8N1 at the codebase UART baud.
REQ-006 cmd  output  16  last fully assembled command, {high byte, low byte}.
REQ-007 cmd_rdy  output  1  level flag: a new cmd is valid.
REQ-008 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-009 resp  input  8  response byte to transmit.
REQ-010 trmt  input  1  one-cycle pulse that starts transmission of resp.
REQ-011 tx_done  output  1  response byte fully transmitted; driven directly from the UART tx_done.

Function
REQ-012 The block SHALL instantiate the existing UART block and connect RX, TX, trmt, tx_data=resp and tx_done straight through; rx_rdy, rx_data and clr_rx_rdy SHALL be used internally only.
REQ-013 Receive FSM states SHALL be IDLE (awaiting the high byte) and LOW (awaiting the low byte); the reset state is IDLE.
REQ-014 IDLE with rx_rdy=1: capture rx_data into the high-byte register, pulse clr_rx_rdy in the same cycle, clear the timeout counter, go to LOW.
REQ-015 LOW with rx_rdy=1: on the next edge load cmd <= {high_reg, rx_data}, set cmd_rdy, pulse clr_rx_rdy in the same cycle, go to IDLE.
REQ-016 cmd SHALL be a register that changes only on command completion (REQ-015); it holds its value while a new command is partially received.
REQ-017 In LOW without rx_rdy, the timeout counter SHALL increment each cycle. When the count reaches TIMEOUT_CYC-1, the FSM SHALL discard the high byte and return to IDLE with cmd and cmd_rdy unchanged.
REQ-018 The counter width SHALL be $clog2(TIMEOUT_CYC); the counter SHALL not wrap; it is held at 0 in IDLE.
REQ-019 Completion and timeout in the same cycle: completion wins.
REQ-020 cmd_rdy SHALL clear on clr_cmd_rdy=1, and SHALL also clear when a high byte is accepted in IDLE (start of a new command).
REQ-021 If a set (REQ-015) and clr_cmd_rdy occur in the same cycle, the set SHALL win.
REQ-022 cmd_rdy SHALL assert exactly 1 cycle after the rx_rdy of the low byte is sampled.
REQ-023 The transmit path SHALL be independent of the receive FSM; a trmt issued while tx_done is pending is the user's responsibility and is not buffered.

Reset
REQ-024 With rst_n=0: FSM=IDLE, cmd=16'h0000, cmd_rdy=0, high_reg=8'h00, timeout counter=0, clr_rx_rdy=0; the UART SHALL be reset by the same rst_n.
REQ-025 Reset in LOW SHALL abandon the partial command; the first byte received after reset is treated as a high byte.

Verification
REQ-026 Send bytes 0x2A then 0x5C on RX -> one cycle after the low-byte rx_rdy: cmd=16'h2A5C, cmd_rdy=1; cmd_rdy stays 1 until clr_cmd_rdy is pulsed, then 0.
REQ-027 Send 0x12, then idle for more than TIMEOUT_CYC cycles (TIMEOUT_CYC=5000 in the bench), then send 0x34, 0x56 -> cmd=16'h3456; no command 0x1234 is ever flagged.
REQ-028 With cmd_rdy=1 and cmd=16'h2A5C, send high byte 0x80 -> cmd_rdy drops when 0x80 is accepted, cmd stays 16'h2A5C; after low byte 0x01: cmd=16'h8001, cmd_rdy=1.
REQ-029 Pulse clr_cmd_rdy in the same cycle cmd_rdy is being set -> cmd_rdy=1 afterwards.
REQ-030 resp=8'hA5, trmt pulsed -> TX carries start, 0xA5 LSB-first, stop; tx_done asserts after the stop bit; the RX command path is undisturbed during this.
REQ-031 Assert rst_n=0 between the high byte 0xFF and the low byte, release it, send 0x00 then 0x07 -> cmd=16'h0007, cmd_rdy=1.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// Two-byte command receiver over an 8N1 UART, with a pass-through response transmitter.
// Contains the UART (uart_rx, uart_tx, uart) and the command-assembly wrapper on top of it.

module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);
  localparam int BW = $clog2(BAUD_DIV);

  logic          rx_ff1, rx_s;
  logic          busy;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      rx_ff1 <= RX;
      rx_s   <= rx_ff1;
    end
  end

  // First sample lands mid start bit; ten samples cover start, data and stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!busy && !rx_s) begin
        busy     <= 1'b1;
        baud_cnt <= BW'(BAUD_DIV / 2);
        bit_cnt  <= '0;
        rx_rdy   <= 1'b0;
      end else if (busy) begin
        if (baud_cnt == '0) begin
          shreg    <= {rx_s, shreg[8:1]};
          baud_cnt <= BW'(BAUD_DIV - 1);
          if (bit_cnt == 4'd9) begin
            busy   <= 1'b0;
            rx_rdy <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt - BW'(1);
        end
      end
    end
  end

  assign rx_data = shreg[7:0];
endmodule

module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_DIV);

  logic          busy;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      tx_done  <= 1'b0;
    end else if (trmt) begin
      busy     <= 1'b1;
      shreg    <= {1'b1, tx_data, 1'b0};
      baud_cnt <= BW'(BAUD_DIV - 1);
      bit_cnt  <= '0;
      tx_done  <= 1'b0;
    end else if (busy) begin
      if (baud_cnt == '0) begin
        baud_cnt <= BW'(BAUD_DIV - 1);
        if (bit_cnt == 4'd9) begin
          busy    <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        baud_cnt <= baud_cnt - BW'(1);
      end
    end
  end

  assign TX = shreg[0];
endmodule

module uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rx_rdy(clr_rx_rdy),
    .rx_rdy(rx_rdy), .rx_data(rx_data)
  );

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
    .TX(TX), .tx_done(tx_done)
  );
endmodule

module uart_cmd_wrapper #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int BAUD_DIV    = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, LOW} state_t;

  state_t           state, nxt_state;
  logic             rx_rdy, clr_rx_rdy;
  logic [7:0]       rx_data;
  logic [7:0]       high_reg;
  logic [CNT_W-1:0] tmo_cnt;
  logic             load_high, load_cmd, cnt_clr, cnt_inc;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .rx_data(rx_data),
    .trmt(trmt), .tx_data(resp), .tx_done(tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // A received low byte beats an expiring timeout in the same cycle.
  always_comb begin
    nxt_state  = state;
    clr_rx_rdy = 1'b0;
    load_high  = 1'b0;
    load_cmd   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rx_rdy) begin
          load_high  = 1'b1;
          clr_rx_rdy = 1'b1;
          nxt_state  = LOW;
        end
      end
      LOW: begin
        if (rx_rdy) begin
          load_cmd   = 1'b1;
          clr_rx_rdy = 1'b1;
          cnt_clr    = 1'b1;
          nxt_state  = IDLE;
        end else if (tmo_cnt == TMO_MAX) begin
          cnt_clr   = 1'b1;
          nxt_state = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tmo_cnt <= '0;
    else if (cnt_clr) tmo_cnt <= '0;
    else if (cnt_inc) tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         high_reg <= 8'h00;
    else if (load_high) high_reg <= rx_data;
  end

  // cmd only moves on completion, so a half-received command never disturbs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cmd <= 16'h0000;
    else if (load_cmd) cmd <= {high_reg, rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cmd_rdy <= 1'b0;
    else if (load_cmd)                  cmd_rdy <= 1'b1;
    else if (load_high || clr_cmd_rdy)  cmd_rdy <= 1'b0;
  end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: command assembly, timeout, ack priority,
// transmit framing and reset abandonment, with a short baud divisor.

module tb_uart_cmd_wrapper;
  localparam int BD  = 16;
  localparam int TMO = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  uart_cmd_wrapper #(.TIMEOUT_CYC(TMO), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); RX = 1'b0;
    repeat (BD - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); RX = b[i];
      repeat (BD - 1) @(negedge clk);
    end
    @(negedge clk); RX = 1'b1;
    repeat (BD - 1) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_cmd: cmd=%h rdy=%b, required 0000/0", cmd, cmd_rdy);
    end
    checks++;
    if (TX !== 1'b1 || tx_done !== 1'b0) begin
      errors++; $display("FAIL reset_tx: TX=%b tx_done=%b, required 1/0", TX, tx_done);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    bit seen;
    seen = 1'b0;
    send_byte(8'h2A);
    fork
      send_byte(8'h5C);
      begin
        for (int i = 0; i < 20 * BD && !seen; i++) begin
          @(negedge clk);
          if (dut.rx_rdy === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (cmd_rdy !== 1'b0) begin
              errors++; $display("FAIL basic_early: cmd_rdy=%b at low rx_rdy, required 0", cmd_rdy);
            end
            @(negedge clk);
            checks++;
            if (cmd_rdy !== 1'b1 || cmd !== 16'h2A5C) begin
              errors++; $display("FAIL basic_latency: cmd=%h rdy=%b, required 2a5c/1", cmd, cmd_rdy);
            end
          end
        end
        if (!seen) begin
          checks++; errors++; $display("FAIL basic_rx_rdy: low byte never received");
        end
      end
    join
    repeat (50) @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_hold: cmd_rdy=%b, required 1", cmd_rdy);
    end
    pulse_clr();
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h2A5C) begin
      errors++; $display("FAIL basic_clear: cmd=%h rdy=%b, required 2a5c/0", cmd, cmd_rdy);
    end
  endtask

  task automatic test_new_cmd();
    send_byte(8'h2A);
    send_byte(8'h5C);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2A5C) begin
      errors++; $display("FAIL newcmd_setup: cmd=%h rdy=%b, required 2a5c/1", cmd, cmd_rdy);
    end
    send_byte(8'h80);
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h2A5C) begin
      errors++; $display("FAIL newcmd_high: cmd=%h rdy=%b, required 2a5c/0", cmd, cmd_rdy);
    end
    send_byte(8'h01);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h8001) begin
      errors++; $display("FAIL newcmd_low: cmd=%h rdy=%b, required 8001/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_set_wins();
    bit seen;
    seen = 1'b0;
    pulse_clr();
    send_byte(8'h11);
    fork
      send_byte(8'h22);
      begin
        for (int i = 0; i < 20 * BD && !seen; i++) begin
          @(negedge clk);
          if (dut.rx_rdy === 1'b1) begin
            seen = 1'b1;
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            checks++;
            if (cmd_rdy !== 1'b1 || cmd !== 16'h1122) begin
              errors++; $display("FAIL set_wins: cmd=%h rdy=%b, required 1122/1", cmd, cmd_rdy);
            end
          end
        end
        if (!seen) begin
          checks++; errors++; $display("FAIL set_wins_rx: low byte never received");
        end
      end
    join
  endtask

  task automatic test_timeout();
    pulse_clr();
    send_byte(8'h12);
    repeat (TMO + 200) @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h1122) begin
      errors++; $display("FAIL tmo_idle: cmd=%h rdy=%b, required 1122/0", cmd, cmd_rdy);
    end
    send_byte(8'h34);
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h1122) begin
      errors++; $display("FAIL tmo_high: cmd=%h rdy=%b, required 1122/0", cmd, cmd_rdy);
    end
    send_byte(8'h56);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h3456) begin
      errors++; $display("FAIL tmo_cmd: cmd=%h rdy=%b, required 3456/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_near_timeout();
    pulse_clr();
    send_byte(8'hBE);
    repeat (TMO - 1000) @(negedge clk);
    send_byte(8'hEF);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'hBEEF) begin
      errors++; $display("FAIL near_tmo: cmd=%h rdy=%b, required beef/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_tx();
    logic [9:0] frame;
    bit         done_seen;
    frame     = {1'b1, 8'hA5, 1'b0};
    done_seen = 1'b0;
    pulse_clr();
    checks++;
    if (tx_done !== 1'b0) begin
      errors++; $display("FAIL tx_idle_done: tx_done=%b, required 0", tx_done);
    end
    fork
      begin
        @(negedge clk); resp = 8'hA5; trmt = 1'b1;
        @(negedge clk); trmt = 1'b0;
        repeat (BD / 2 - 1) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
          checks++;
          if (TX !== frame[k]) begin
            errors++; $display("FAIL tx_bit%0d: TX=%b, required %b", k, TX, frame[k]);
          end
          if (k == 9) begin
            checks++;
            if (tx_done !== 1'b0) begin
              errors++; $display("FAIL tx_done_early: tx_done=%b in stop bit, required 0", tx_done);
            end
          end else begin
            repeat (BD) @(negedge clk);
          end
        end
        for (int i = 0; i < 2 * BD && !done_seen; i++) begin
          @(negedge clk);
          if (tx_done === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (!done_seen) begin
          errors++; $display("FAIL tx_done: tx_done=%b after stop bit, required 1", tx_done);
        end
      end
      begin
        send_byte(8'hC3);
        send_byte(8'h3C);
      end
    join
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'hC33C) begin
      errors++; $display("FAIL tx_rx_path: cmd=%h rdy=%b, required c33c/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hFF);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: cmd=%h rdy=%b, required 0000/0", cmd, cmd_rdy);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h07);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h0007) begin
      errors++; $display("FAIL rst_mid_cmd: cmd=%h rdy=%b, required 0007/1", cmd, cmd_rdy);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    resp        = 8'h00;
    trmt        = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_new_cmd();
    test_set_wins();
    test_timeout();
    test_near_timeout();
    test_tx();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
